operand_a_ctrl: RTL and testbench

Controller that owns the operand-A register file of the matrix-multiply datapath. It arbitrates the file's single address/write port between host element writes and the compute engine's read sequence. On start it reads the stored N×N operand element by element and packs each row into a BUS_WIDTH word. It then streams the rows to the engine over a valid/ready handshake.

---
 rtl/operand_a_ctrl_if.sv | 24 ++
 rtl/operand_a_ctrl.sv | 97 +++++++++
 tb/tb_operand_a_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_a_ctrl_if.sv
// operand_a_ctrl_if: host element-write bus and row-stream handshake bundle
interface operand_a_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
);
  logic                       host_wr_i;
  logic [ADDR_WIDTH-1:0]      host_addr_i;
  logic [DATA_WIDTH-1:0]      host_data_i;
  logic                       host_ready_o;
  logic                       row_valid_o;
  logic [BUS_WIDTH-1:0]       row_data_o;
  logic [$clog2(MAX_DIM):0]   row_idx_o;
  logic                       row_ready_i;
  modport master (
    output host_wr_i, host_addr_i, host_data_i, row_ready_i,
    input  host_ready_o, row_valid_o, row_data_o, row_idx_o
  );
  modport slave (
    input  host_wr_i, host_addr_i, host_data_i, row_ready_i,
    output host_ready_o, row_valid_o, row_data_o, row_idx_o
  );
endinterface

// File: rtl/operand_a_ctrl.sv
// operand_a_ctrl: operand-A register-file arbiter and row packer/streamer (OPA_TRANSPOSE_EN streams columns)
module operand_a_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  operand_a_ctrl_if.slave            bus,
  input  logic                       start_i,
  input  logic [$clog2(MAX_DIM):0]   dim_i,
  output logic                       rf_we_o,
  output logic [ADDR_WIDTH-1:0]      rf_addr_o,
  output logic [DATA_WIDTH-1:0]      rf_wdata_o,
  input  logic [DATA_WIDTH-1:0]      rf_rdata_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);
  localparam int CW = $clog2(MAX_DIM) + 1;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] n_q, row_q, col_q;
  logic [BUS_WIDTH-1:0] buf_q;
  logic pend_q, err_q;
  logic go, dim_bad, addr_bad, col_last, row_last;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  assign go       = state_q == IDLE && (start_i || pend_q) && !bus.host_wr_i;
  assign dim_bad  = dim_i == '0 || dim_i > CW'(MAX_DIM);
  assign addr_bad = bus.host_addr_i >= ADDR_WIDTH'(MAX_DIM * MAX_DIM);
  assign col_last = col_q == n_q - CW'(1);
  assign row_last = row_q == n_q - CW'(1);
`ifdef OPA_TRANSPOSE_EN
  assign fetch_addr = ADDR_WIDTH'(col_q) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(row_q);
`else
  assign fetch_addr = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(col_q);
`endif
  assign bus.row_valid_o = state_q == SEND;
  assign bus.row_data_o  = buf_q;
  assign bus.row_idx_o   = row_q;
  assign busy_o          = state_q != IDLE;
  assign done_o          = state_q == DONE;
  assign err_o           = err_q;
  // state register
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  // next state and register-file port arbitration: host owns the port only in IDLE
  always_comb begin
    state_d          = state_q;
    bus.host_ready_o = 1'b0;
    rf_we_o          = 1'b0;
    rf_addr_o        = '0;
    rf_wdata_o       = '0;
    case (state_q)
      IDLE: begin
        bus.host_ready_o = 1'b1;
        rf_we_o          = bus.host_wr_i && !addr_bad;
        rf_addr_o        = bus.host_wr_i ? bus.host_addr_i : '0;
        rf_wdata_o       = bus.host_wr_i ? bus.host_data_i : '0;
        state_d          = go && !dim_bad ? FETCH : IDLE;
      end
      FETCH: begin
        rf_addr_o = fetch_addr;
        state_d   = col_last ? SEND : FETCH;
      end
      SEND:    state_d = bus.row_ready_i ? (row_last ? DONE : FETCH) : SEND;
      default: state_d = IDLE;
    endcase
  end
  // start pending flag, error pulse, counters and row packing buffer
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) begin
      n_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
      buf_q  <= '0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= state_q == IDLE && !go && (pend_q || start_i);
      err_q  <= state_q == IDLE && (bus.host_wr_i ? addr_bad : go && dim_bad);
      if (go) begin
        n_q   <= dim_i;
        row_q <= '0;
        col_q <= '0;
        buf_q <= '0;
      end
      if (state_q == FETCH) begin
        for (int j = 0; j < MAX_DIM; j++)
          if (col_q == CW'(j)) buf_q[j*DATA_WIDTH +: DATA_WIDTH] <= rf_rdata_i;
        col_q <= col_last ? '0 : col_q + CW'(1);
      end
      if (state_q == SEND && bus.row_ready_i && !row_last) row_q <= row_q + CW'(1);
    end
endmodule

// File: tb/tb_operand_a_ctrl.sv
// tb_operand_a_ctrl: vector table, corner sequences and random streams against a matrix model
module tb_operand_a_ctrl;
  localparam int DW = 32, BW = 64, AW = 32, MD = 2;
`ifdef OPA_TRANSPOSE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif
  logic clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic [1:0] dim_i = '0;
  logic rf_we_o, busy_o, done_o, err_o;
  logic [AW-1:0] rf_addr_o;
  logic [DW-1:0] rf_wdata_o, rf_rdata_i;
  logic [DW-1:0] rf_mem [MD*MD];
  logic [DW-1:0] mat [MD][MD];
  logic [BW-1:0] got [MD];
  int total = 0, passed = 0;
  operand_a_ctrl_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(MD)) bus ();
  operand_a_ctrl #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(MD)) dut (
    .clk(clk), .rst_ni(rst_ni), .bus(bus), .start_i(start_i), .dim_i(dim_i),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_wdata_o(rf_wdata_o), .rf_rdata_i(rf_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rf_we_o && rf_addr_o < MD*MD) rf_mem[rf_addr_o[1:0]] <= rf_wdata_o;
  assign rf_rdata_i = rf_addr_o < MD*MD ? rf_mem[rf_addr_o[1:0]] : '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] exp_row(input int k, input int n);
    logic [BW-1:0] w = '0;
    for (int j = 0; j < n; j++) w[j*DW +: DW] = TR ? mat[j][k] : mat[k][j];
    return w;
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit exp_err);
    bus.host_wr_i = 1'b1; bus.host_addr_i = a; bus.host_data_i = d;
    @(negedge clk);
    chk("wr_host_ready", bus.host_ready_o, 1);
    chk("wr_rf_we", rf_we_o, {63'd0, !exp_err});
    cyc();
    bus.host_wr_i = 1'b0;
    if (!exp_err) mat[a/MD][a%MD] = d;
    @(negedge clk);
    chk("wr_err_pulse", err_o, {63'd0, exp_err});
    cyc();
    @(negedge clk);
    chk("wr_err_clear", err_o, 0);
    cyc();
  endtask

  task automatic kick(input int n);
    start_i = 1'b1; dim_i = 2'(n);
    cyc();
    start_i = 1'b0;
  endtask

  task automatic collect(input int n, input bit rnd, input bit timing);
    int c = 0, rows = 0;
    bit done_seen = 0, first_v = 0, stall = 0;
    logic [BW-1:0] pd = '0;
    logic [1:0] pi = '0;
    while (!done_seen && c < 200) begin
      bus.row_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      chk("busy_in_stream", busy_o, 1);
      if (stall) begin
        chk("hold_valid", bus.row_valid_o, 1);
        chk("hold_data", bus.row_data_o, pd);
        chk("hold_idx", bus.row_idx_o, pi);
      end
      if (bus.row_valid_o && !first_v) begin
        first_v = 1;
        if (timing) chk("first_valid_cycle", c, n);
      end
      if (bus.row_valid_o && bus.row_ready_i) begin
        if (rows < n) chk("row_data", bus.row_data_o, exp_row(rows, n));
        chk("row_idx", bus.row_idx_o, rows);
        if (rows < MD) got[rows] = bus.row_data_o;
        rows++;
      end
      stall = bus.row_valid_o && !bus.row_ready_i;
      pd = bus.row_data_o; pi = bus.row_idx_o;
      if (done_o) begin
        done_seen = 1;
        if (timing) chk("done_cycle", c, n * (n + 1));
      end
      cyc();
      c++;
    end
    chk("done_seen", done_seen, 1);
    chk("row_count", rows, n);
    bus.row_ready_i = 1'b0;
    @(negedge clk);
    chk("idle_after_done", busy_o, 0);
    chk("done_one_cycle", done_o, 0);
    chk("no_err_stream", err_o, 0);
    cyc();
  endtask

  typedef struct {
    bit is_start;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int dim;
    bit exp_err;
    logic [BW-1:0] r0;
    logic [BW-1:0] r1;
  } vec_t;
  vec_t tbl [10];

  initial begin
    bus.host_wr_i = 1'b0; bus.host_addr_i = '0; bus.host_data_i = '0; bus.row_ready_i = 1'b0;
    for (int i = 0; i < MD*MD; i++) begin rf_mem[i] = '0; mat[i/MD][i%MD] = '0; end
    tbl[0] = '{1'b0, 32'd0, 32'h11, 0, 1'b0, 64'h0, 64'h0};
    tbl[1] = '{1'b0, 32'd1, 32'h22, 0, 1'b0, 64'h0, 64'h0};
    tbl[2] = '{1'b0, 32'd2, 32'h33, 0, 1'b0, 64'h0, 64'h0};
    tbl[3] = '{1'b0, 32'd3, 32'h44, 0, 1'b0, 64'h0, 64'h0};
    tbl[4] = '{1'b0, 32'd4, 32'h99, 0, 1'b1, 64'h0, 64'h0};
    tbl[5] = '{1'b1, 32'd0, 32'h0, 2, 1'b0,
               TR ? 64'h00000033_00000011 : 64'h00000022_00000011,
               TR ? 64'h00000044_00000022 : 64'h00000044_00000033};
    tbl[6] = '{1'b1, 32'd0, 32'h0, 1, 1'b0, 64'h00000000_00000011, 64'h0};
    tbl[7] = '{1'b1, 32'd0, 32'h0, 0, 1'b1, 64'h0, 64'h0};
    tbl[8] = '{1'b1, 32'd0, 32'h0, 3, 1'b1, 64'h0, 64'h0};
    tbl[9] = '{1'b0, 32'hFFFF_FFFF, 32'h77, 0, 1'b1, 64'h0, 64'h0};
    @(negedge clk);
    chk("rst_host_ready", bus.host_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", bus.row_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rf_we", rf_we_o, 0);
    chk("rst_rf_addr", rf_addr_o, 0);
    chk("rst_row_data", bus.row_data_o, 0);
    chk("rst_row_idx", bus.row_idx_o, 0);
    cyc();
    rst_ni = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      if (!tbl[i].is_start) wr(tbl[i].addr, tbl[i].data, tbl[i].exp_err);
      else if (tbl[i].exp_err) begin
        kick(tbl[i].dim);
        @(negedge clk);
        chk("dim_err_pulse", err_o, 1);
        chk("dim_err_idle", busy_o, 0);
        chk("dim_err_no_valid", bus.row_valid_o, 0);
        cyc();
        @(negedge clk);
        chk("dim_err_clear", err_o, 0);
        chk("dim_err_still_idle", busy_o, 0);
        cyc();
      end else begin
        kick(tbl[i].dim);
        collect(tbl[i].dim, 1'b0, 1'b1);
        chk("vec_row0", got[0], tbl[i].r0);
        if (tbl[i].dim > 1) chk("vec_row1", got[1], tbl[i].r1);
      end
    end
    // stall in SEND for 5 cycles, with a host write attempted while busy
    kick(2);
    for (int i = 0; i < 10 && !bus.row_valid_o; i++) begin
      @(negedge clk);
      if (!bus.row_valid_o) cyc();
    end
    chk("stall_reach_send", bus.row_valid_o, 1);
    bus.host_wr_i = 1'b1; bus.host_addr_i = 32'd0; bus.host_data_i = 32'hDEAD;
    #1;
    chk("busy_host_ready", bus.host_ready_o, 0);
    chk("busy_rf_we", rf_we_o, 0);
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", bus.row_valid_o, 1);
      chk("stall_data", bus.row_data_o, exp_row(0, 2));
      chk("stall_idx", bus.row_idx_o, 0);
      cyc();
      @(negedge clk);
    end
    cyc();
    bus.host_wr_i = 1'b0;
    collect(2, 1'b0, 1'b0);
    chk("busy_write_blocked", rf_mem[0], mat[0][0]);
    // start and host write in the same cycle: write wins, start stays pending
    start_i = 1'b1; dim_i = 2'd2;
    bus.host_wr_i = 1'b1; bus.host_addr_i = 32'd1; bus.host_data_i = 32'h55;
    @(negedge clk);
    chk("same_cycle_we", rf_we_o, 1);
    cyc();
    start_i = 1'b0; bus.host_wr_i = 1'b0;
    mat[0][1] = 32'h55;
    @(negedge clk);
    chk("pending_still_idle", busy_o, 0);
    cyc();
    collect(2, 1'b0, 1'b1);
    // asynchronous reset during the second row's fetch
    kick(2);
    bus.row_ready_i = 1'b1;
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("fetch2_no_valid", bus.row_valid_o, 0);
    chk("fetch2_row_idx", bus.row_idx_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_host_ready", bus.host_ready_o, 1);
    chk("arst_row_idx", bus.row_idx_o, 0);
    chk("arst_row_data", bus.row_data_o, 0);
    chk("arst_rf_addr", rf_addr_o, 0);
    cyc();
    @(negedge clk);
    chk("arst_no_done", done_o, 0);
    cyc();
    rst_ni = 1'b1;
    bus.row_ready_i = 1'b0;
    cyc();
    @(negedge clk);
    chk("arst_no_restart", busy_o, 0);
    cyc();
    kick(2);
    collect(2, 1'b0, 1'b1);
    // randomized writes and streams against the matrix model
    for (int it = 0; it < 15; it++) begin
      for (int w = 0; w < 3; w++) begin
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 5));
        wr(a, $urandom, a >= MD*MD);
      end
      begin
        int n;
        n = $urandom_range(1, 2);
        kick(n);
        collect(n, 1'b1, 1'b0);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
